// File: rtl/pixel_replication_2_if.sv
// Source-RAM read port and output-RAM write port of the 2x pixel replicator.
// master = replicator side, slave = RAM/sink side.
interface pixel_replication_2_if;
    logic [14:0] R_ADDR;
    logic [7:0]  PIXEL_IN;
    logic [16:0] W_ADDR;
    logic [7:0]  W_DATA;
    logic        W_EN;
    logic        W_READY;
    logic [8:0]  X_OUT_COORD;
    logic [7:0]  Y_OUT_COORD;

    modport master (
        output R_ADDR,
        input  PIXEL_IN,
        output W_ADDR,
        output W_DATA,
        output W_EN,
        input  W_READY,
        output X_OUT_COORD,
        output Y_OUT_COORD
    );

    modport slave (
        input  R_ADDR,
        output PIXEL_IN,
        input  W_ADDR,
        input  W_DATA,
        input  W_EN,
        output W_READY,
        input  X_OUT_COORD,
        input  Y_OUT_COORD
    );
endinterface

// File: rtl/pixel_replication_2.sv
// 2x nearest-neighbour upscaler: scans the output frame, reads the source pixel at
// (x>>1, y>>1) through a 1-cycle sync RAM and writes it out with W_READY backpressure.
module pixel_replication_2 #(
    parameter int SHIFT_FACTOR  = 1,
    parameter int IMG_WIDTH_IN  = 160,
    parameter int IMG_HEIGHT_IN = 120
) (
    input  logic CLK,
    input  logic RESET,
    input  logic START,
    output logic BUSY,
    output logic DONE,
    pixel_replication_2_if.master bus
);
    localparam int IMG_WIDTH_OUT  = IMG_WIDTH_IN << SHIFT_FACTOR;
    localparam int IMG_HEIGHT_OUT = IMG_HEIGHT_IN << SHIFT_FACTOR;
    localparam logic [8:0] X_LAST = 9'(IMG_WIDTH_OUT - 1);
    localparam logic [7:0] Y_LAST = 8'(IMG_HEIGHT_OUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_e;

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
    } coord_t;

    state_e      state_q, state_d;
    coord_t      scan_q, scan_d;
    coord_t      pipe_q, pipe_d;
    logic        vld_q, vld_d;
    logic [14:0] r_addr_q, r_addr_d;

    logic        adv, issue, accept, last_px;
    logic [8:0]  src_x;
    logic [7:0]  src_y;
    logic [14:0] rd_addr;

    // Constant multiplies by the row pitch fold to shift-adds (160 = 128+32, 320 = 256+64).
    always_comb begin
        src_x   = scan_q.x >> SHIFT_FACTOR;
        src_y   = scan_q.y >> SHIFT_FACTOR;
        rd_addr = 15'(src_y) * 15'(IMG_WIDTH_IN) + 15'(src_x);
        adv     = !vld_q || bus.W_READY;
        issue   = (state_q == S_RUN) && adv;
        accept  = vld_q && bus.W_READY;
        last_px = (scan_q.x == X_LAST) && (scan_q.y == Y_LAST);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (START) state_d = S_RUN;
            S_RUN:   if (issue && last_px) state_d = S_DRAIN;
            S_DRAIN: if (accept) state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        BUSY = 1'b0;
        DONE = 1'b0;
        case (state_q)
            S_RUN, S_DRAIN: BUSY = 1'b1;
            S_FIN: begin
                BUSY = 1'b1;
                DONE = 1'b1;
            end
            default: ;
        endcase
    end

    // A stalled write freezes scan, pipe and the issued read address together.
    always_comb begin
        scan_d   = scan_q;
        pipe_d   = pipe_q;
        vld_d    = vld_q;
        r_addr_d = r_addr_q;
        case (state_q)
            S_RUN: begin
                if (adv) begin
                    pipe_d   = scan_q;
                    vld_d    = 1'b1;
                    r_addr_d = rd_addr;
                    if (scan_q.x == X_LAST) begin
                        scan_d.x = '0;
                        scan_d.y = (scan_q.y == Y_LAST) ? '0 : scan_q.y + 8'd1;
                    end else begin
                        scan_d.x = scan_q.x + 9'd1;
                    end
                end
            end
            S_DRAIN: if (bus.W_READY) vld_d = 1'b0;
            S_FIN: begin
                vld_d    = 1'b0;
                pipe_d   = '0;
                r_addr_d = '0;
            end
            default: begin
                vld_d  = 1'b0;
                scan_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            scan_q   <= '0;
            pipe_q   <= '0;
            vld_q    <= 1'b0;
            r_addr_q <= '0;
        end else begin
            scan_q   <= scan_d;
            pipe_q   <= pipe_d;
            vld_q    <= vld_d;
            r_addr_q <= r_addr_d;
        end
    end

    // While held, R_ADDR repeats the last issued address so PIXEL_IN stays on the held write.
    always_comb begin
        bus.R_ADDR      = issue ? rd_addr : r_addr_q;
        bus.W_EN        = vld_q;
        bus.W_DATA      = vld_q ? bus.PIXEL_IN : 8'd0;
        bus.W_ADDR      = vld_q ? 17'(pipe_q.y) * 17'(IMG_WIDTH_OUT) + 17'(pipe_q.x) : 17'd0;
        bus.X_OUT_COORD = vld_q ? pipe_q.x : 9'd0;
        bus.Y_OUT_COORD = vld_q ? pipe_q.y : 8'd0;
    end
endmodule

// File: tb/tb_pixel_replication_2.sv
// Bench for pixel_replication_2: a full-size instance for the 320x240 smoke/corner run and a
// reduced 16x12-output instance for backpressure, final stall, mid-frame reset and back-to-back.
module tb_pixel_replication_2;
    localparam int FW_IN = 160;
    localparam int FH_IN = 120;
    localparam int SW_IN = 8;
    localparam int SH_IN = 6;
    localparam int MAXPIX = 4 * FW_IN * FH_IN;

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    logic start_f = 1'b0;
    logic start_s = 1'b0;
    logic w_ready = 1'b1;
    logic busy_f, done_f, busy_s, done_s;

    pixel_replication_2_if bf();
    pixel_replication_2_if bs();

    pixel_replication_2 #(.SHIFT_FACTOR(1), .IMG_WIDTH_IN(FW_IN), .IMG_HEIGHT_IN(FH_IN)) dut_full (
        .CLK(CLK), .RESET(RESET), .START(start_f), .BUSY(busy_f), .DONE(done_f), .bus(bf));
    pixel_replication_2 #(.SHIFT_FACTOR(1), .IMG_WIDTH_IN(SW_IN), .IMG_HEIGHT_IN(SH_IN)) dut_small (
        .CLK(CLK), .RESET(RESET), .START(start_s), .BUSY(busy_s), .DONE(done_s), .bus(bs));

    always #5 CLK = ~CLK;

    assign bf.W_READY = w_ready;
    assign bs.W_READY = w_ready;

    function automatic logic [7:0] src_pix(input int a, input int w);
        return 8'(((a % w) + (a / w)) & 255);
    endfunction

    function automatic logic [7:0] exp_pix(input int a, input int ow);
        int x, y;
        x = a % ow;
        y = a / ow;
        return 8'(((x / 2) + (y / 2)) & 255);
    endfunction

    function automatic int exp_raddr(input int a, input int ow, input int iw);
        return ((a / ow) / 2) * iw + (a % ow) / 2;
    endfunction

    // Source frame RAMs: synchronous read, one cycle latency
    always @(posedge CLK) begin
        bf.PIXEL_IN <= src_pix(int'(bf.R_ADDR), FW_IN);
        bs.PIXEL_IN <= src_pix(int'(bs.R_ADDR), SW_IN);
    end

    bit sel = 1'b0;
    int ow, oh, iw, total;
    logic        m_en, m_busy, m_done;
    logic [16:0] m_addr;
    logic [7:0]  m_data;
    logic [8:0]  m_x;
    logic [7:0]  m_y;
    logic [14:0] m_raddr;

    always_comb begin
        iw = sel ? SW_IN : FW_IN;
        ow = 2 * iw;
        oh = sel ? 2 * SH_IN : 2 * FH_IN;
        total = ow * oh;
        if (sel) begin
            m_en = bs.W_EN; m_busy = busy_s; m_done = done_s; m_addr = bs.W_ADDR;
            m_data = bs.W_DATA; m_x = bs.X_OUT_COORD; m_y = bs.Y_OUT_COORD; m_raddr = bs.R_ADDR;
        end else begin
            m_en = bf.W_EN; m_busy = busy_f; m_done = done_f; m_addr = bf.W_ADDR;
            m_data = bf.W_DATA; m_x = bf.X_OUT_COORD; m_y = bf.Y_OUT_COORD; m_raddr = bf.R_ADDR;
        end
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int frame_id = 0;
    int mon_id = 0;
    int wr_cnt, dup_cnt, range_err, coord_err, data_err, pair_err, stab_err, en_err;
    int done_cnt, done_at, acc_last, first_a;
    int rc[4];
    int seen_id[MAXPIX];
    logic [7:0] outd[MAXPIX];
    logic        prev_stall;
    logic [16:0] prev_addr;
    logic [7:0]  prev_data;
    logic [14:0] prev_raddr;
    int stall_obs, stall_busy_err;

    // Scoreboard: each accepted write is checked against the model and logged
    always @(negedge CLK) begin
        if (frame_id != mon_id) begin
            mon_id <= frame_id;
            wr_cnt <= 0; dup_cnt <= 0; range_err <= 0; coord_err <= 0; data_err <= 0;
            pair_err <= 0; stab_err <= 0; en_err <= 0; done_cnt <= 0; done_at <= -1;
            acc_last <= -1; first_a <= -1; prev_stall <= 1'b0;
            for (int i = 0; i < 4; i++) rc[i] <= -1;
        end else if (RESET) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (m_addr !== prev_addr || m_data !== prev_data || m_en !== 1'b1))
                stab_err <= stab_err + 1;
            if (m_en && w_ready) begin
                wr_cnt <= wr_cnt + 1;
                if (wr_cnt == 0) first_a <= int'(m_addr);
                if (int'(m_addr) >= total) range_err <= range_err + 1;
                else begin
                    if (seen_id[m_addr] == mon_id) dup_cnt <= dup_cnt + 1;
                    seen_id[m_addr] <= mon_id;
                    outd[m_addr] <= m_data;
                end
                if (int'(m_x) != int'(m_addr) % ow || int'(m_y) != int'(m_addr) / ow)
                    coord_err <= coord_err + 1;
                if (m_data !== exp_pix(int'(m_addr), ow)) data_err <= data_err + 1;
                if (int'(prev_raddr) != exp_raddr(int'(m_addr), ow, iw)) pair_err <= pair_err + 1;
                if (int'(m_addr) == ow - 1) rc[0] <= int'(prev_raddr);
                if (int'(m_addr) == ow) rc[1] <= int'(prev_raddr);
                if (int'(m_addr) == 2 * ow) rc[2] <= int'(prev_raddr);
                if (int'(m_addr) == total - 1) begin
                    rc[3] <= int'(prev_raddr);
                    acc_last <= cyc;
                end
            end
            if (m_done) begin
                done_cnt <= done_cnt + 1;
                done_at <= cyc;
            end
            if (m_en && !m_busy) en_err <= en_err + 1;
            prev_stall <= m_en && !w_ready;
            prev_addr <= m_addr;
            prev_data <= m_data;
            prev_raddr <= m_raddr;
        end
    end

    // mode 0: ready always, 1: random ready, 2: hold the final write for 5 cycles
    task automatic run_frame(input int mode, input int restart_at, input int rst_write, input int limit);
        int stall;
        stall = 0; stall_obs = 0; stall_busy_err = 0;
        frame_id++;
        @(posedge CLK); #1;
        w_ready = 1'b1;
        if (sel) start_s = 1'b1; else start_f = 1'b1;
        @(posedge CLK); #1;
        start_s = 1'b0; start_f = 1'b0;
        cyc = 1;
        forever begin
            if (done_cnt != 0 || cyc > limit) break;
            if (rst_write != 0 && wr_cnt >= rst_write) begin
                RESET = 1'b1;
                break;
            end
            case (mode)
                1: w_ready = 1'($urandom_range(0, 1));
                2: if (m_en && int'(m_addr) == total - 1 && stall < 5) begin
                       w_ready = 1'b0;
                       stall++;
                       stall_obs++;
                       if (!m_busy || m_done) stall_busy_err++;
                   end else w_ready = 1'b1;
                default: w_ready = 1'b1;
            endcase
            if (restart_at != 0 && cyc == restart_at) begin
                if (sel) start_s = 1'b1; else start_f = 1'b1;
            end else begin
                start_s = 1'b0; start_f = 1'b0;
            end
            @(posedge CLK); #1;
            cyc++;
        end
        start_s = 1'b0; start_f = 1'b0; w_ready = 1'b1;
    endtask

    task automatic test_reset();
        #2 RESET = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        checks++; if (bf.R_ADDR !== 15'd0) begin failures++; $display("FAIL reset_r_addr got=%0d exp=0", bf.R_ADDR); end
        checks++; if (bf.W_ADDR !== 17'd0) begin failures++; $display("FAIL reset_w_addr got=%0d exp=0", bf.W_ADDR); end
        checks++; if (bf.W_DATA !== 8'd0) begin failures++; $display("FAIL reset_w_data got=%0d exp=0", bf.W_DATA); end
        checks++; if (bf.W_EN !== 1'b0) begin failures++; $display("FAIL reset_w_en got=%0b exp=0", bf.W_EN); end
        checks++; if ({bf.X_OUT_COORD, bf.Y_OUT_COORD} !== 17'd0) begin failures++; $display("FAIL reset_coords got=%0d/%0d exp=0/0", bf.X_OUT_COORD, bf.Y_OUT_COORD); end
        checks++; if ({busy_f, done_f} !== 2'b00) begin failures++; $display("FAIL reset_busy_done got=%b exp=00", {busy_f, done_f}); end
        checks++; if ({bs.R_ADDR, bs.W_ADDR, bs.W_DATA, bs.W_EN, busy_s, done_s} !== '0) begin failures++; $display("FAIL reset_small_outputs got=nonzero exp=0"); end
        @(posedge CLK); #1 RESET = 1'b0;
    endtask

    task automatic test_full_frame();
        sel = 1'b0;
        run_frame(0, 1000, 0, 77000);
        repeat (5) @(posedge CLK);
        #1;
        checks++; if (wr_cnt != 76800) begin failures++; $display("FAIL full_write_count got=%0d exp=76800", wr_cnt); end
        checks++; if (done_at != 76802) begin failures++; $display("FAIL full_done_cycle got=%0d exp=76802", done_at); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL full_done_pulses got=%0d exp=1", done_cnt); end
        checks++; if (busy_f !== 1'b0) begin failures++; $display("FAIL full_busy_after got=%0b exp=0", busy_f); end
        checks++; if (dup_cnt + range_err != 0) begin failures++; $display("FAIL full_dup_or_range got=%0d exp=0", dup_cnt + range_err); end
        checks++; if (data_err != 0) begin failures++; $display("FAIL full_data_errors got=%0d exp=0", data_err); end
        checks++; if (coord_err != 0) begin failures++; $display("FAIL full_coord_errors got=%0d exp=0", coord_err); end
        checks++; if (pair_err != 0) begin failures++; $display("FAIL full_raddr_pairing got=%0d exp=0", pair_err); end
        checks++; if (en_err != 0) begin failures++; $display("FAIL full_wen_outside_busy got=%0d exp=0", en_err); end
        checks++; if (first_a != 0) begin failures++; $display("FAIL full_first_addr got=%0d exp=0", first_a); end
        checks++; if ({outd[0], outd[1], outd[320], outd[321]} !== 32'h0) begin failures++; $display("FAIL smoke_block0 got=%h exp=00000000", {outd[0], outd[1], outd[320], outd[321]}); end
        checks++; if (outd[2] !== 8'h01) begin failures++; $display("FAIL smoke_addr2 got=%h exp=01", outd[2]); end
        checks++; if (outd[76799] !== 8'h16) begin failures++; $display("FAIL smoke_last got=%h exp=16", outd[76799]); end
        checks++; if (rc[0] != 159) begin failures++; $display("FAIL corner_319_0 got=%0d exp=159", rc[0]); end
        checks++; if (rc[1] != 0) begin failures++; $display("FAIL corner_0_1 got=%0d exp=0", rc[1]); end
        checks++; if (rc[2] != 160) begin failures++; $display("FAIL corner_0_2 got=%0d exp=160", rc[2]); end
        checks++; if (rc[3] != 19199) begin failures++; $display("FAIL corner_319_239 got=%0d exp=19199", rc[3]); end
    endtask

    task automatic test_backpressure();
        sel = 1'b1;
        run_frame(1, 0, 0, 3000);
        checks++; if (wr_cnt != 192) begin failures++; $display("FAIL bp_write_count got=%0d exp=192", wr_cnt); end
        checks++; if (dup_cnt + range_err != 0) begin failures++; $display("FAIL bp_dup_or_range got=%0d exp=0", dup_cnt + range_err); end
        checks++; if (data_err != 0) begin failures++; $display("FAIL bp_data_errors got=%0d exp=0", data_err); end
        checks++; if (stab_err != 0) begin failures++; $display("FAIL bp_hold_stability got=%0d exp=0", stab_err); end
        checks++; if (pair_err + coord_err != 0) begin failures++; $display("FAIL bp_addr_pairing got=%0d exp=0", pair_err + coord_err); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL bp_done_pulses got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_final_stall();
        sel = 1'b1;
        run_frame(2, 0, 0, 2000);
        checks++; if (stall_obs != 5) begin failures++; $display("FAIL stall_cycles got=%0d exp=5", stall_obs); end
        checks++; if (stall_busy_err != 0) begin failures++; $display("FAIL stall_left_drain got=%0d exp=0", stall_busy_err); end
        checks++; if (acc_last != 198) begin failures++; $display("FAIL stall_accept_cycle got=%0d exp=198", acc_last); end
        checks++; if (done_at != 199) begin failures++; $display("FAIL stall_done_cycle got=%0d exp=199", done_at); end
        checks++; if (wr_cnt != 192 || done_cnt != 1) begin failures++; $display("FAIL stall_counts got=%0d/%0d exp=192/1", wr_cnt, done_cnt); end
        checks++; if (rc[3] != 47) begin failures++; $display("FAIL stall_last_raddr got=%0d exp=47", rc[3]); end
    endtask

    task automatic test_mid_reset();
        sel = 1'b1;
        run_frame(0, 0, 100, 2000);
        #1;
        checks++; if (RESET !== 1'b1 || wr_cnt != 100) begin failures++; $display("FAIL mreset_trigger got=%0d exp=100", wr_cnt); end
        checks++; if ({bs.W_EN, bs.W_ADDR, bs.W_DATA} !== '0) begin failures++; $display("FAIL mreset_write_port got=%0b/%0d/%0d exp=0/0/0", bs.W_EN, bs.W_ADDR, bs.W_DATA); end
        checks++; if ({bs.R_ADDR, bs.X_OUT_COORD, bs.Y_OUT_COORD} !== '0) begin failures++; $display("FAIL mreset_addr_coords got=%0d/%0d/%0d exp=0/0/0", bs.R_ADDR, bs.X_OUT_COORD, bs.Y_OUT_COORD); end
        checks++; if ({busy_s, done_s} !== 2'b00) begin failures++; $display("FAIL mreset_busy_done got=%b exp=00", {busy_s, done_s}); end
        @(posedge CLK); #1 RESET = 1'b0;
        checks++; if (done_cnt != 0) begin failures++; $display("FAIL mreset_done_pulsed got=%0d exp=0", done_cnt); end
        run_frame(0, 0, 0, 2000);
        checks++; if (first_a != 0) begin failures++; $display("FAIL mreset_restart_addr got=%0d exp=0", first_a); end
        checks++; if (wr_cnt != 192 || data_err != 0) begin failures++; $display("FAIL mreset_restart_frame got=%0d/%0d exp=192/0", wr_cnt, data_err); end
        checks++; if (done_at != 194) begin failures++; $display("FAIL mreset_restart_done got=%0d exp=194", done_at); end
    endtask

    task automatic test_back_to_back();
        sel = 1'b1;
        for (int f = 0; f < 2; f++) begin
            run_frame(0, 0, 0, 2000);
            checks++; if (wr_cnt != 192 || done_at != 194) begin failures++; $display("FAIL b2b_frame%0d got=%0d/%0d exp=192/194", f, wr_cnt, done_at); end
            checks++; if (rc[0] != 7 || rc[1] != 0 || rc[2] != 8 || rc[3] != 47) begin failures++; $display("FAIL b2b_corners%0d got=%0d,%0d,%0d,%0d exp=7,0,8,47", f, rc[0], rc[1], rc[2], rc[3]); end
            checks++; if (data_err + dup_cnt + en_err != 0) begin failures++; $display("FAIL b2b_errors%0d got=%0d exp=0", f, data_err + dup_cnt + en_err); end
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_backpressure();
        test_final_stall();
        test_mid_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
